// File: rtl/f_subtraction_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | f_subtraction_seq : multi-cycle IEEE-754 subtractor (OUT_SUB = A - B)      |
// | Optional macro F_SUB_ROUND_NEAREST_EN adds GRS bits and RNE rounding.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module f_subtraction_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [EXP_W+MAN_W:0] A,
  input  logic [EXP_W+MAN_W:0] B,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 ZERO,
  output logic [EXP_W+MAN_W:0] OUT_SUB
);

`ifdef F_SUB_ROUND_NEAREST_EN
  localparam int GW = 3;
`else
  localparam int GW = 0;
`endif
  localparam int DW = EXP_W + MAN_W + 1;
  localparam int MW = MAN_W + 1 + GW;    // aligned mantissa: hidden + fraction + GRS
  localparam int SW = MW + 1;            // sum adds a carry bit on top
  localparam int H  = MAN_W + GW;        // hidden-bit index inside the sum
  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] MAX_SH   = EXP_W'(MAN_W + 1);
  localparam logic [DW-1:0]    QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, PACK} state_t;
  state_t state_q, state_d;

  logic             a_sign_q, a_sign_d, b_sign_q, b_sign_d;
  logic [EXP_W-1:0] a_exp_q, a_exp_d, b_exp_q, b_exp_d;
  logic [MAN_W:0]   a_man_q, a_man_d, b_man_q, b_man_d;
  logic             nan_q, nan_d, eff_sub_q, eff_sub_d;
  logic             sign_q, sign_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [MW-1:0]    xm_q, xm_d, ym_q, ym_d;
  logic [SW-1:0]    man_q, man_d;
  logic [DW-1:0]    out_q, out_d;
  logic             done_q, done_d, zero_q, zero_d;

  logic             swap, x_sign;
  logic [EXP_W-1:0] x_exp, y_exp, shamt;
  logic [MAN_W:0]   x_man, y_man;
  logic [MW-1:0]    y_ext, y_al;
  logic [EXP_W-1:0] pack_exp;
  logic [MAN_W-1:0] pack_frac;
  logic [DW-1:0]    pack_res;
`ifdef F_SUB_ROUND_NEAREST_EN
  logic [MW-1:0]    lost;
  logic             round_up;
  logic [MAN_W:0]   rnd;
`endif

  // Alignment: larger magnitude becomes X; ties keep A.
  always_comb begin
    swap   = {b_exp_q, b_man_q} > {a_exp_q, a_man_q};
    x_sign = swap ? b_sign_q : a_sign_q;
    x_exp  = swap ? b_exp_q  : a_exp_q;
    x_man  = swap ? b_man_q  : a_man_q;
    y_exp  = swap ? a_exp_q  : b_exp_q;
    y_man  = swap ? a_man_q  : b_man_q;
    shamt  = x_exp - y_exp;
    y_ext  = MW'(y_man) << GW;
    y_al   = (shamt > MAX_SH) ? '0 : (y_ext >> shamt);
`ifdef F_SUB_ROUND_NEAREST_EN
    lost   = y_ext & ((MW'(1) << shamt) - MW'(1));
    y_al[0] = (shamt > MAX_SH) ? (|y_man) : (y_al[0] | (|lost));
`endif
  end

  always_comb begin
    pack_exp  = exp_q;
    pack_frac = man_q[H-1:GW];
`ifdef F_SUB_ROUND_NEAREST_EN
    round_up = man_q[GW-1] & (man_q[GW-2] | man_q[GW-3] | man_q[GW]);
    rnd      = {1'b0, man_q[H-1:GW]} + (MAN_W+1)'(round_up);
    if (exp_q != EXP_ONES) begin
      pack_frac = rnd[MAN_W-1:0];
      if (rnd[MAN_W]) pack_exp = exp_q + EXP_W'(1);
    end
`endif
    if (nan_q)                    pack_res = QNAN;
    else if (pack_exp == EXP_ONES) pack_res = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
    else                          pack_res = {sign_q, pack_exp, pack_frac};
  end

  always_comb begin
    state_d   = state_q;
    a_sign_d  = a_sign_q;  a_exp_d = a_exp_q;  a_man_d = a_man_q;
    b_sign_d  = b_sign_q;  b_exp_d = b_exp_q;  b_man_d = b_man_q;
    nan_d     = nan_q;     eff_sub_d = eff_sub_q;
    sign_d    = sign_q;    exp_d   = exp_q;
    xm_d      = xm_q;      ym_d    = ym_q;     man_d = man_q;
    out_d     = out_q;     zero_d  = zero_q;   done_d = 1'b0;
    case (state_q)
      IDLE: if (START) begin
        a_sign_d = A[DW-1];
        a_exp_d  = A[DW-2:MAN_W];
        a_man_d  = (A[DW-2:MAN_W] == '0) ? '0 : {1'b1, A[MAN_W-1:0]};
        b_sign_d = ~B[DW-1];
        b_exp_d  = B[DW-2:MAN_W];
        b_man_d  = (B[DW-2:MAN_W] == '0) ? '0 : {1'b1, B[MAN_W-1:0]};
        nan_d    = (A[DW-2:MAN_W] == EXP_ONES) | (B[DW-2:MAN_W] == EXP_ONES);
        state_d  = ALIGN;
      end
      ALIGN: begin
        sign_d    = x_sign;
        exp_d     = x_exp;
        xm_d      = MW'(x_man) << GW;
        ym_d      = y_al;
        eff_sub_d = a_sign_q ^ b_sign_q;
        state_d   = ADD;
      end
      ADD: begin
        man_d   = eff_sub_q ? ({1'b0, xm_q} - {1'b0, ym_q}) : ({1'b0, xm_q} + {1'b0, ym_q});
        state_d = NORM;
      end
      NORM: begin
        state_d = PACK;
        if (nan_q) begin
          state_d = PACK;
        end else if (man_q[SW-1]) begin
          man_d = man_q >> 1;
`ifdef F_SUB_ROUND_NEAREST_EN
          man_d[0] = man_q[1] | man_q[0];
`endif
          exp_d = exp_q + EXP_W'(1);
        end else if (man_q == '0) begin
          sign_d = 1'b0;
          exp_d  = '0;
        end else if (!man_q[H] && (exp_q > EXP_W'(1))) begin
          man_d   = man_q << 1;
          exp_d   = exp_q - EXP_W'(1);
          state_d = NORM;
        end else if (!man_q[H]) begin
          // Would need a denormal: flush to +0.
          sign_d = 1'b0;
          exp_d  = '0;
          man_d  = '0;
        end
      end
      PACK: begin
        out_d   = pack_res;
        zero_d  = (pack_res[DW-2:0] == '0);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      a_sign_q <= 1'b0; a_exp_q <= '0; a_man_q <= '0;
      b_sign_q <= 1'b0; b_exp_q <= '0; b_man_q <= '0;
      nan_q    <= 1'b0; eff_sub_q <= 1'b0;
      sign_q   <= 1'b0; exp_q <= '0;
      xm_q     <= '0;   ym_q  <= '0;  man_q <= '0;
      out_q    <= '0;   zero_q <= 1'b0; done_q <= 1'b0;
    end else begin
      a_sign_q <= a_sign_d; a_exp_q <= a_exp_d; a_man_q <= a_man_d;
      b_sign_q <= b_sign_d; b_exp_q <= b_exp_d; b_man_q <= b_man_d;
      nan_q    <= nan_d;    eff_sub_q <= eff_sub_d;
      sign_q   <= sign_d;   exp_q <= exp_d;
      xm_q     <= xm_d;     ym_q  <= ym_d;  man_q <= man_d;
      out_q    <= out_d;    zero_q <= zero_d; done_q <= done_d;
    end
  end

  assign BUSY    = (state_q != IDLE);
  assign DONE    = done_q;
  assign ZERO    = zero_q;
  assign OUT_SUB = out_q;

endmodule
`default_nettype wire
